// File: rtl/imm_encoder.sv
// imm_encoder: packs RV64 instruction fields and a 64-bit immediate into 32-bit instruction words.
//   clk_i, rst_i (async, active-high)
//   req_valid_i/req_ready_o, req_fmt_i, req_opcode_i, req_funct3_i, req_funct7_i,
//   req_rd_i, req_rs1_i, req_rs2_i, req_imm_i : encode request
//   instr_valid_o/instr_ready_i, instr_o, instr_err_o, instr_last_o : encoded word stream
module imm_encoder #(
  parameter int          XLEN      = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_fmt_i,
  input  logic [6:0]      req_opcode_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [6:0]      req_funct7_i,
  input  logic [4:0]      req_rd_i,
  input  logic [4:0]      req_rs1_i,
  input  logic [4:0]      req_rs2_i,
  input  logic [XLEN-1:0] req_imm_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic            instr_err_o,
  output logic            instr_last_o
);
  typedef enum logic [1:0] {IDLE, OUT, LI_HI} state_t;
  state_t      r_state;
  logic        r_valid;
  logic [31:0] r_instr;
  logic        r_err;
  logic        r_last;
  logic [31:0] r_lo_word;
  logic [31:0] w_word;
  logic        w_err;
  logic        w_two;
  logic [31:0] w_lo_word;
  logic [19:0] w_hi;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic        w_fit32;
  logic        w_accept;
  logic        w_hs;
  logic        w_unused;
  assign w_unused  = req_funct7_i[0];
  assign w_fit12   = &req_imm_i[XLEN-1:11] | ~|req_imm_i[XLEN-1:11];
  assign w_fit13   = &req_imm_i[XLEN-1:12] | ~|req_imm_i[XLEN-1:12];
  assign w_fit21   = &req_imm_i[XLEN-1:20] | ~|req_imm_i[XLEN-1:20];
  assign w_fit32   = &req_imm_i[XLEN-1:31] | ~|req_imm_i[XLEN-1:31];
  // LUI upper part rounds up when the ADDIW low part is negative (bit 11 set)
  assign w_hi      = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
  assign w_lo_word = {req_imm_i[11:0], req_rd_i, 3'b000, req_rd_i, 7'b0011011};
  assign w_hs      = r_valid & instr_ready_i;
  assign req_ready_o = (r_state == IDLE) | (w_hs & r_last);
  assign w_accept  = req_valid_i & req_ready_o;
  always_comb begin
    w_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
    w_err  = ~w_fit12 | (req_fmt_i == 3'd7);
    w_two  = 1'b0;
    case (req_fmt_i)
      3'd1: begin
        w_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i, req_imm_i[4:0], req_opcode_i};
        w_err  = ~w_fit12;
      end
      3'd2: begin
        w_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                  req_imm_i[4:1], req_imm_i[11], req_opcode_i};
        w_err  = ~w_fit13 | req_imm_i[0];
      end
      3'd3: begin
        w_word = {req_imm_i[31:12], req_rd_i, req_opcode_i};
        w_err  = ~w_fit32 | |req_imm_i[11:0];
      end
      3'd4: begin
        w_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12], req_rd_i, req_opcode_i};
        w_err  = ~w_fit21 | req_imm_i[0];
      end
      3'd5: begin
        w_word = {req_funct7_i[6:1], req_imm_i[5:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
        w_err  = |req_imm_i[XLEN-1:6];
      end
      3'd6: begin
        w_word = w_fit12 ? {req_imm_i[11:0], 5'd0, 3'b000, req_rd_i, 7'b0010011}
               : w_fit32 ? {w_hi, req_rd_i, 7'b0110111} : NOP_INSTR;
        w_err  = ~w_fit12 & ~w_fit32;
        w_two  = ~w_fit12 & w_fit32;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_err     <= 1'b0;
      r_last    <= 1'b0;
      r_lo_word <= '0;
    end else if (w_accept) begin
      r_state   <= w_two ? LI_HI : OUT;
      r_valid   <= 1'b1;
      r_instr   <= w_word;
      r_err     <= w_err;
      r_last    <= ~w_two;
      r_lo_word <= w_lo_word;
    end else if (w_hs) begin
      r_state <= (r_state == LI_HI) ? OUT : IDLE;
      r_valid <= r_state == LI_HI;
      r_instr <= (r_state == LI_HI) ? r_lo_word : r_instr;
      r_err   <= 1'b0;
      r_last  <= 1'b1;
    end
  end
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_err_o   = r_err;
  assign instr_last_o  = r_last;
endmodule
